// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and defaults for the UART TX scheduler
// Purpose: defaults for byte width and watchdog length, the scheduler state
//          encoding, and the round-robin index helper used by rr_arbiter.
// Ports:   none (package).
package uart_pkg;

  localparam int UART_DATA_W      = 8;
  localparam int UART_TIMEOUT_CYC = 200000;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_RECOVER   = 2'd3
  } sched_state_t;

  // Index reached by stepping 'off' places past 'last' in an n-entry ring.
  function automatic int rr_next(input int last, input int off, input int n);
    return (last + off) % n;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// rtl/uart_tx_scheduler_if.sv - requester and UART TX signal bundle
// Purpose: groups the requester handshake and the UART TX control/status
//          signals seen by uart_tx_scheduler.
// Ports (signals):
//   enable, req_valid[N_REQ], req_data[N_REQ*DATA_W]  requester side, into scheduler
//   req_ready[N_REQ]                                  one-hot accept, out of scheduler
//   tx_en, tx_rst, tx_data[DATA_W]                    UART TX controls, out of scheduler
//   tx_busy, tx_done                                  UART TX status, into scheduler
//   grant_id, grant_valid, timeout_err                status, out of scheduler
// Modports: slave = scheduler view, master = environment view.
interface uart_tx_scheduler_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8
) ();

  localparam int GID_W = $clog2(N_REQ);

  logic                      enable;
  logic [N_REQ-1:0]          req_valid;
  logic [N_REQ*DATA_W-1:0]   req_data;
  logic [N_REQ-1:0]          req_ready;
  logic                      tx_en;
  logic                      tx_rst;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_busy;
  logic                      tx_done;
  logic [GID_W-1:0]          grant_id;
  logic                      grant_valid;
  logic                      timeout_err;

  modport slave (
    input  enable, req_valid, req_data, tx_busy, tx_done,
    output req_ready, tx_en, tx_rst, tx_data, grant_id, grant_valid, timeout_err
  );

  modport master (
    output enable, req_valid, req_data, tx_busy, tx_done,
    input  req_ready, tx_en, tx_rst, tx_data, grant_id, grant_valid, timeout_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick among N_REQ requests
// Purpose: finds the first asserted request scanning last+1, last+2, ...
//          (mod N_REQ) and returns it one-hot and as an index.
// Ports:
//   i_req[N_REQ]   request vector
//   i_last[IDX_W]  index granted most recently (lowest priority now)
//   o_grant[N_REQ] one-hot winner, zero when no request
//   o_idx[IDX_W]   winner index, zero when no request
//   o_any          at least one request present
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [IDX_W-1:0] w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    // Offset N_REQ wraps back to 'last' itself, so a lone requester keeps winning.
    for (int off = 1; off <= N_REQ; off++) begin
      w_cand = IDX_W'(rr_next(int'(i_last), off, N_REQ));
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin sharing of one UART transmitter
// Purpose: arbitrates N_REQ byte requesters onto a single UART TX, issues the
//          tx_en start pulse, waits for tx_done and recovers with tx_rst when
//          tx_done does not arrive within TIMEOUT_CYC cycles.
// Ports:
//   PCLK     system clock, rising edge
//   PRESETn  asynchronous active-low reset
//   bus      uart_tx_scheduler_if.slave: enable, req_valid/req_data/req_ready,
//            tx_en/tx_rst/tx_data, tx_busy/tx_done, grant_id/grant_valid/timeout_err
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = UART_DATA_W,
  parameter int TIMEOUT_CYC = UART_TIMEOUT_CYC
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  uart_tx_scheduler_if.slave   bus
);

  localparam int GID_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  sched_state_t       r_state;
  logic [GID_W-1:0]   r_last;
  logic [GID_W-1:0]   r_grant_id;
  logic [DATA_W-1:0]  r_tx_data;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_tx_en;
  logic               r_tx_rst;
  logic               r_timeout_err;
  logic               r_grant_valid;

  logic [N_REQ-1:0]   w_grant;
  logic [GID_W-1:0]   w_idx;
  logic               w_any;
  logic               w_can_grant;
  logic [N_REQ-1:0]   w_ready;
  logic               w_accept;
  logic [DATA_W-1:0]  w_win_data;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (GID_W)
  ) u_arb (
    .i_req   (bus.req_valid),
    .i_last  (r_last),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // PRESETn in the gate keeps req_ready low while reset is held, not just after an edge.
  assign w_can_grant = (r_state == ST_IDLE) & bus.enable & ~bus.tx_busy & w_any & PRESETn;
  assign w_ready     = w_can_grant ? w_grant : '0;
  assign w_accept    = |(w_ready & bus.req_valid);
  assign w_win_data  = bus.req_data[w_idx*DATA_W +: DATA_W];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state       <= ST_IDLE;
      r_last        <= GID_W'(N_REQ - 1);
      r_grant_id    <= '0;
      r_tx_data     <= '0;
      r_cnt         <= '0;
      r_tx_en       <= 1'b0;
      r_tx_rst      <= 1'b0;
      r_timeout_err <= 1'b0;
      r_grant_valid <= 1'b0;
    end else begin
      r_tx_en       <= 1'b0;
      r_tx_rst      <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_tx_data     <= w_win_data;
            r_grant_id    <= w_idx;
            r_last        <= w_idx;
            r_grant_valid <= 1'b1;
            r_tx_en       <= 1'b1;
            r_state       <= ST_START;
          end
        end
        ST_START: begin
          // A tx_done here belongs to an earlier frame and is deliberately ignored.
          r_cnt   <= '0;
          r_state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          // tx_done takes priority over a watchdog expiry in the same cycle.
          if (bus.tx_done) begin
            r_grant_valid <= 1'b0;
            r_state       <= ST_IDLE;
          end else if (r_cnt == CNT_LAST) begin
            r_tx_rst      <= 1'b1;
            r_timeout_err <= 1'b1;
            r_state       <= ST_RECOVER;
          end
        end
        ST_RECOVER: begin
          // The byte is abandoned; r_last already points at it so the next requester is favoured.
          r_grant_valid <= 1'b0;
          r_state       <= ST_IDLE;
        end
        default: begin
          r_grant_valid <= 1'b0;
          r_state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = w_ready;
  assign bus.tx_en       = r_tx_en;
  assign bus.tx_rst      = r_tx_rst;
  assign bus.tx_data     = r_tx_data;
  assign bus.grant_id    = r_grant_id;
  assign bus.grant_valid = r_grant_valid;
  assign bus.timeout_err = r_timeout_err;

endmodule
